// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the register file / scoreboard slice.
package regfile_pkg;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_ADDR_W = 5;
  localparam int unsigned ZERO_ADDR  = 0;

  // Bit offset of port 'port' inside a packed multi-port bus of 'width'-bit lanes.
  function automatic int unsigned slice_lsb(input int unsigned port, input int unsigned width);
    return port * width;
  endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// One combinational read port: array lookup with zero-register and write-bypass overrides.
module regfile_rd_port
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1
) (
  input  logic [ADDR_W-1:0]      rd_addr,
  input  logic [DATA_W-1:0]      entries [1 << ADDR_W],
  input  logic [(1<<ADDR_W)-1:0] pending,
  input  logic                   wr_valid,
  input  logic [ADDR_W-1:0]      wr_addr,
  input  logic [DATA_W-1:0]      wr_data,
  output logic [DATA_W-1:0]      rd_data,
  output logic                   rd_busy
);

  logic is_zero;
  logic hit;

  assign is_zero = (ZERO_REG != 0) && (rd_addr == ADDR_W'(ZERO_ADDR));
  assign hit     = (BYPASS != 0) && wr_valid && (wr_addr == rd_addr);

  // Zero register overrides bypass, which overrides stored state.
  always_comb begin
    rd_data = entries[rd_addr];
    rd_busy = pending[rd_addr];
    if (hit) begin
      rd_data = wr_data;
      rd_busy = 1'b0;
    end
    if (is_zero) begin
      rd_data = '0;
      rd_busy = 1'b0;
    end
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// Parametrised register file with optional zero register, write bypass and per-entry pending bits.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr,
  input  logic                     flush,
  output logic                     any_busy
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] entries [DEPTH];
  logic [DEPTH-1:0]  pending;
  logic [DEPTH-1:0]  pending_next;
  logic              wr_ok;
  logic              rsv_ok;
  logic              wr_valid;

  assign wr_ok  = wr_en  && !((ZERO_REG != 0) && (wr_addr  == ADDR_W'(ZERO_ADDR)));
  assign rsv_ok = rsv_en && !((ZERO_REG != 0) && (rsv_addr == ADDR_W'(ZERO_ADDR)));

  // Bypass is suppressed while reset is held so every read port returns zero.
  assign wr_valid = wr_en & rst;

  // Next pending state: write clears, a same-edge reservation re-sets, flush clears everything.
  always_comb begin
    pending_next = pending;
    if (wr_ok)  pending_next[wr_addr]  = 1'b0;
    if (rsv_ok) pending_next[rsv_addr] = 1'b1;
    if (flush)  pending_next = '0;
  end

  // Storage array update from writeback.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) entries[i] <= '0;
    end else if (wr_ok) begin
      entries[wr_addr] <= wr_data;
    end
  end

  // Pending bits and their registered summary; any_busy tracks the freshly updated vector.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending  <= '0;
      any_busy <= 1'b0;
    end else begin
      pending  <= pending_next;
      any_busy <= |pending_next;
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    regfile_rd_port #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .ZERO_REG(ZERO_REG),
      .BYPASS  (BYPASS)
    ) u_rd (
      .rd_addr (rd_addr[slice_lsb(i, ADDR_W) +: ADDR_W]),
      .entries (entries),
      .pending (pending),
      .wr_valid(wr_valid),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_data (rd_data[slice_lsb(i, DATA_W) +: DATA_W]),
      .rd_busy (rd_busy[i])
    );
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: two configurations driven in lockstep against an array model.
module tb_regfile_scoreboard;

  logic         clk = 1'b0;
  logic         rst;
  logic [4:0]   ra [4];
  logic         wr_en;
  logic [4:0]   wr_addr;
  logic [31:0]  wr_data;
  logic         rsv_en;
  logic [4:0]   rsv_addr;
  logic         flush;

  logic [63:0]  rd_data_a;
  logic [1:0]   rd_busy_a;
  logic         any_a;
  logic [127:0] rd_data_b;
  logic [3:0]   rd_busy_b;
  logic         any_b;

  int tests = 0;
  int fails = 0;

  // Model: index 0 = zero-reg + bypass config, index 1 = plain config without bypass.
  logic [31:0] m_mem  [2][32];
  logic [31:0] m_pend [2];

  always #5 clk = ~clk;

  regfile_scoreboard #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1), .BYPASS(1)) dut_a (
    .clk(clk), .rst(rst), .rd_addr({ra[1], ra[0]}), .rd_data(rd_data_a), .rd_busy(rd_busy_a),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .flush(flush), .any_busy(any_a)
  );

  regfile_scoreboard #(.DATA_W(32), .ADDR_W(5), .NUM_RD(4), .ZERO_REG(0), .BYPASS(0)) dut_b (
    .clk(clk), .rst(rst), .rd_addr({ra[3], ra[2], ra[1], ra[0]}), .rd_data(rd_data_b),
    .rd_busy(rd_busy_b), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rsv_en(rsv_en),
    .rsv_addr(rsv_addr), .flush(flush), .any_busy(any_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_data(input int c, input logic [4:0] a);
    if (c == 0 && a == 5'd0) return 32'd0;
    if (c == 0 && rst === 1'b1 && wr_en && wr_addr == a) return wr_data;
    return m_mem[c][a];
  endfunction

  function automatic logic exp_busy(input int c, input logic [4:0] a);
    if (c == 0 && a == 5'd0) return 1'b0;
    if (c == 0 && rst === 1'b1 && wr_en && wr_addr == a) return 1'b0;
    return m_pend[c][a];
  endfunction

  task automatic check_all();
    for (int p = 0; p < 2; p++) begin
      chk($sformatf("a_data%0d@%0d", p, ra[p]), rd_data_a[p*32 +: 32], exp_data(0, ra[p]));
      chk($sformatf("a_busy%0d@%0d", p, ra[p]), {31'd0, rd_busy_a[p]}, {31'd0, exp_busy(0, ra[p])});
    end
    for (int p = 0; p < 4; p++) begin
      chk($sformatf("b_data%0d@%0d", p, ra[p]), rd_data_b[p*32 +: 32], exp_data(1, ra[p]));
      chk($sformatf("b_busy%0d@%0d", p, ra[p]), {31'd0, rd_busy_b[p]}, {31'd0, exp_busy(1, ra[p])});
    end
    chk("a_any", {31'd0, any_a}, {31'd0, m_pend[0] != 32'd0});
    chk("b_any", {31'd0, any_b}, {31'd0, m_pend[1] != 32'd0});
  endtask

  task automatic model_clear();
    for (int c = 0; c < 2; c++) begin
      m_pend[c] = '0;
      for (int a = 0; a < 32; a++) m_mem[c][a] = '0;
    end
  endtask

  // Effect of one clock edge: the newest producer decides the pending bit, flush dominates.
  task automatic model_edge();
    if (rst !== 1'b1) return;
    for (int c = 0; c < 2; c++) begin
      logic ok_w, ok_r;
      ok_w = wr_en  && !(c == 0 && wr_addr  == 5'd0);
      ok_r = rsv_en && !(c == 0 && rsv_addr == 5'd0);
      if (ok_w) m_mem[c][wr_addr] = wr_data;
      if (flush) m_pend[c] = '0;
      else begin
        if (ok_w) m_pend[c][wr_addr]  = 1'b0;
        if (ok_r) m_pend[c][rsv_addr] = 1'b1;
      end
    end
  endtask

  task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic re, input logic [4:0] rs, input logic fl);
    wr_en = we; wr_addr = wa; wr_data = wd; rsv_en = re; rsv_addr = rs; flush = fl;
  endtask

  task automatic rd(input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] a3);
    ra[0] = a0; ra[1] = a1; ra[2] = a2; ra[3] = a3;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0);
  endtask

  // Inputs are applied 1 time unit after a rising edge; check before the next edge, then after it.
  task automatic cycle();
    #2;
    check_all();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  initial begin
    rst = 1'b0;
    model_clear();
    rd(5'd9, 5'd10, 5'd11, 5'd12);
    drive(1'b1, 5'd9, 32'h55, 1'b0, 5'd0, 1'b0);
    #1;
    cycle();
    cycle();

    // Reset release, successive writes, then swapped reads
    rst = 1'b1;
    drive(1'b1, 5'd9,  32'h55, 1'b0, 5'd0, 1'b0); cycle();
    drive(1'b1, 5'd10, 32'h0F, 1'b0, 5'd0, 1'b0); cycle();
    drive(1'b1, 5'd11, 32'h0C, 1'b0, 5'd0, 1'b0); cycle();
    idle(); rd(5'd9, 5'd10, 5'd11, 5'd9);  cycle();
    chk("rb_9",  rd_data_a[31:0],  32'h55);
    chk("rb_10", rd_data_a[63:32], 32'h0F);
    rd(5'd10, 5'd9, 5'd9, 5'd10); cycle();

    // Bypass vs. no bypass on the same write
    rd(5'd11, 5'd11, 5'd11, 5'd11);
    drive(1'b1, 5'd11, 32'h77, 1'b0, 5'd0, 1'b0);
    #2;
    chk("byp_a", rd_data_a[31:0], 32'h77);
    chk("nobyp_b", rd_data_b[31:0], 32'h0C);
    #2; cycle();
    idle(); cycle();

    // Zero register
    rd(5'd0, 5'd0, 5'd0, 5'd0);
    drive(1'b1, 5'd0, 32'hDEADBEEF, 1'b1, 5'd0, 1'b0); cycle();
    idle(); cycle();
    chk("zr_b_data", rd_data_b[31:0], 32'hDEADBEEF);
    chk("zr_a_any", {31'd0, any_a}, 32'd0);
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1); cycle();

    // Scoreboard reserve / writeback release
    rd(5'd5, 5'd5, 5'd5, 5'd0);
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 1'b0); cycle();
    chk("sb_busy5", {31'd0, rd_busy_a[0]}, 32'd1);
    idle(); cycle();
    drive(1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 1'b0); cycle();
    idle(); cycle();
    chk("sb_any_clear", {31'd0, any_a}, 32'd0);

    // Collisions
    rd(5'd7, 5'd8, 5'd7, 5'd8);
    drive(1'b1, 5'd7, 32'hA7, 1'b1, 5'd7, 1'b0); cycle();
    idle(); cycle();
    chk("col_rsv_wr", {31'd0, rd_busy_a[0]}, 32'd1);
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd8, 1'b1); cycle();
    idle(); cycle();
    drive(1'b1, 5'd8, 32'hAB, 1'b0, 5'd0, 1'b1); cycle();
    idle(); cycle();
    chk("col_flush_wr", rd_data_a[63:32], 32'hAB);

    // Async reset mid-run, then four distinct reads on the 4-port instance
    drive(1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 1'b0); cycle();
    drive(1'b1, 5'd4, 32'h44, 1'b1, 5'd3, 1'b0); cycle();
    rd(5'd3, 5'd4, 5'd3, 5'd4);
    drive(1'b1, 5'd3, 32'h99, 1'b1, 5'd4, 1'b0);
    #1;
    rst = 1'b0;
    model_clear();
    #1;
    check_all();
    chk("arst_any", {31'd0, any_b}, 32'd0);
    rst = 1'b1;
    idle();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
    for (int k = 1; k <= 4; k++) begin
      drive(1'b1, 5'(k), 32'h1000 + 32'(k), 1'b0, 5'd0, 1'b0); cycle();
    end
    idle(); rd(5'd1, 5'd2, 5'd3, 5'd4); cycle();
    chk("p4_port3", rd_data_b[127:96], 32'h1004);

    // Randomized traffic on a narrow address range to force collisions
    for (int n = 0; n < 400; n++) begin
      rd(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
         5'($urandom_range(0, 7)), 5'($urandom_range(0, 31)));
      drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
            1'($urandom_range(0, 2) == 0 ? 1 : 0) | 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 7)), 1'($urandom_range(0, 15) == 0 ? 1 : 0));
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
